// File: rtl/fetch_queue.sv
// Instruction-fetch queue: issues pc to a 1-cycle synchronous imem, buffers
// returned words with their pc, and presents the head to decode with
// credit-based back-pressure to program_counter.
module fetch_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    output logic        imem_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        stall,
    input  logic        flush,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_valid,
    output logic        keep_pc
);

    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned SUM_W = PTR_W + 2;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } entry_t;

    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               inflight_q, inflight_d;
    logic [31:0]        inflight_pc_q, inflight_pc_d;
    entry_t             head_q, head_d;
    logic               valid_q, valid_d;
    logic               keep_pc_q, keep_pc_d;

    logic               issue;
    logic               wr_en;
    logic               rd_en;

    // Next-state: issue, return, dequeue and flush; head/credit precomputed so outputs are flops
    always_comb begin
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        head_d        = '0;
        issue         = flush | ~keep_pc_q;
        wr_en         = inflight_q & ~flush;
        rd_en         = (count_q != '0) & ~stall & ~flush;
        inflight_d    = issue;
        inflight_pc_d = issue ? pc : inflight_pc_q;

        if (flush) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(wr_en) - CNT_W'(rd_en);
        end

        // Credit counts queued entries plus the word still in memory
        keep_pc_d = (SUM_W'(count_d) + SUM_W'(inflight_d)) >= SUM_W'(DEPTH);
        valid_d   = (count_d != '0);

        // New head is either the word landing this cycle or an existing entry
        if (valid_d) begin
            if (wr_en && (wr_ptr_q == rd_ptr_d)) begin
                head_d = '{inst: imem_data, pc: inflight_pc_q};
            end else begin
                head_d = mem_q[rd_ptr_d];
            end
        end
    end

    // Control and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            head_q        <= '0;
            valid_q       <= 1'b0;
            keep_pc_q     <= 1'b0;
        end else begin
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            head_q        <= head_d;
            valid_q       <= valid_d;
            keep_pc_q     <= keep_pc_d;
        end
    end

    // Entry storage; contents are don't-care after reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= '{inst: imem_data, pc: inflight_pc_q};
        end
    end

    assign imem_en    = issue;
    assign imem_addr  = pc;
    assign inst       = head_q.inst;
    assign inst_pc    = head_q.pc;
    assign inst_valid = valid_q;
    assign keep_pc    = keep_pc_q;

`ifndef SYNTHESIS
    // Credit rule must keep a returning word from ever hitting a full queue
    enq_not_full: assert property (@(posedge clk) disable iff (!reset)
        !(wr_en && (count_q == CNT_W'(DEPTH))));
`endif

endmodule
